// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell, LSB first; done fires WIDTH cycles after the accepting edge.
// No backpressure: start is accepted in IDLE or DONE and ignored while busy.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    // Only the bits that survive into the final sum are kept; the LSB of a
    // full-width result shifter would be shifted out without ever being read.
    logic [WIDTH-2:0] r_sr;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_c_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_sr_nxt;

    assign w_s      = r_sa[0] ^ r_sb[0] ^ r_c;
    assign w_c_nxt  = (r_sa[0] & r_sb[0]) | (r_c & (r_sa[0] ^ r_sb[0]));
    assign w_sr_nxt = {w_s, r_sr};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sr    <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_sr    <= '0;
                        r_c     <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_sr  <= w_sr_nxt[WIDTH-1:1];
                    r_c   <= w_c_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum   <= w_sr_nxt;
                        r_cout  <= w_c_nxt;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

    a_done_pulse: assert property (@(posedge clk) disable iff (rst) r_done |=> !r_done);
    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(r_busy && r_done));
    a_busy_state: assert property (@(posedge clk) disable iff (rst) r_busy == (r_state == ST_SHIFT));

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder. It is the additive counterpart to the lab's combinational subtractor blocks. A start pulse loads two WIDTH-bit operands, and the block processes one bit per clock, LSB first, through a single full-adder cell and a registered carry. It then presents the registered sum and carry-out with a one-cycle done pulse. It sits in the lab datapath as the area-minimal add stage behind a simple start/done handshake.

## Interface
- WIDTH, 8, operand and sum width in bits (legal range 2 to 32)

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block is idle or in the done cycle
- a  input  WIDTH  augend; captured on the accepting edge only
- b  input  WIDTH  addend; captured on the accepting edge only
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle onward
- sum  output  WIDTH  registered result; holds the last completed result
- cout  output  1  registered carry-out of the last completed addition

## Operation
- States: IDLE, SHIFT, DONE. Encoding is free.
- Internal registers:
  - operand shift registers sa and sb
  - result shift register sr
  - carry flip-flop c
  - bit counter cnt, clog2(WIDTH)+1 bits
- IDLE or DONE with start=1:
  - load sa<=a, sb<=b, c<=0, cnt<=0
  - go to SHIFT
- IDLE with start=0: remain in IDLE.
- DONE with start=0: go to IDLE.
- SHIFT, every cycle:
  - s = sa[0]^sb[0]^c
  - c <= (sa[0]&sb[0]) | (c&(sa[0]^sb[0]))
  - sa and sb shift right by one
  - sr shifts right with s entering at the MSB
  - cnt increments
- SHIFT when cnt=WIDTH-1:
  - sum <= {s, sr[WIDTH-1:1]}, i.e. the final shifted value
  - cout <= carry out of this bit
  - go to DONE
- start while in SHIFT is ignored. Operands already captured are unaffected, and a and b may change freely.
- sum and cout change only on the completing edge. They hold their value during SHIFT, IDLE and DONE.
- busy=1 exactly in SHIFT. done=1 exactly in DONE.
- Arithmetic is unsigned modulo 2^WIDTH, with the overflow bit on cout. {cout,sum} = a+b as a WIDTH+1-bit value.

## Timing
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, c=0, cnt=0. Reset overrides start.
- Reset asserted mid-SHIFT:
  - the operation is aborted
  - no done pulse is generated
  - sum and cout return to 0
- Latency: start is sampled high at edge E0.
  - busy=1 from E0 through E0+WIDTH.
  - sum, cout and done update at edge E0+WIDTH.
  - done is high for the single cycle between E0+WIDTH and E0+WIDTH+1.
- Throughput: start held or re-asserted in the DONE cycle is accepted at edge E0+WIDTH+1.
  - The next operation begins without an IDLE cycle.
  - The issue interval is WIDTH+1 cycles.
  - done still pulses once per operation.
- start held high continuously produces back-to-back operations. The operands are re-sampled at each accepting edge.
- No combinational path from any input to any output.

## Test plan
- WIDTH=8, a=0x0F, b=0x01, start pulsed at E0:
  - busy high for 8 cycles
  - done at E0+8 with sum=0x10, cout=0
- a=0xFF, b=0x01 -> sum=0x00, cout=1, done single-cycle. Also a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- Start 0x12+0x34. At E0+3, pulse start with a=0xAA, b=0x55 and change a and b every cycle -> done at E0+8 with sum=0x46, cout=0. Exactly one done pulse.
- Start 0x80+0x80, assert rst at E0+4 for one cycle:
  - busy=0, sum=0, cout=0 next cycle
  - no done pulse
  - a following 0x01+0x02 yields sum=0x03
- start held high with operand pairs (0x01,0x01), (0x7F,0x01), (0xF0,0x20) presented on each accepting edge:
  - done pulses at E0+8, E0+17, E0+26
  - sums 0x02/0, 0x80/0, 0x10/1
- Randomized check, 200 pairs: {cout,sum} == a+b at every done, and sum/cout stable between done pulses.
